keyboard_tx: RTL and testbench

KEYBOARD_TX -- requirements
Module: keyboard_tx

---
 rtl/keyboard_tx.sv | 221 ++++++++++++++++++++++
 tb/tb_keyboard_tx.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/keyboard_tx.sv
// keyboard_tx: PS/2 host-to-device command transmitter (inhibit, request-to-send, 11-bit frame,
// ACK sampling). Both open-drain pull-low enables are driven straight from flip-flops.
module keyboard_tx #(
    parameter int unsigned INHIBIT_CYCLES = 10000,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic       keyboard_clk,
    input  logic       keyboard_rstn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       kclk_in,
    input  logic       kdata_in,
    output logic       kclk_oe,
    output logic       kdata_oe
);

    localparam int unsigned InhW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int unsigned TimW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StRts,
        StSend,
        StAck,
        StWaitIdle,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        data_q, data_d;
    logic              parity_q, parity_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [InhW-1:0]   inh_cnt_q, inh_cnt_d;
    logic [TimW-1:0]   to_cnt_q, to_cnt_d;
    logic              err_q, err_d;

    logic              kclk_oe_q, kclk_oe_d;
    logic              kdata_oe_q, kdata_oe_d;
    logic              tx_ready_q, tx_ready_d;
    logic              tx_done_q, tx_done_d;
    logic              tx_err_q, tx_err_d;

    logic              kclk_meta_q, kclk_sync_q, kclk_prev_q;
    logic              kdata_meta_q, kdata_sync_q;

    logic              fe;
    logic              timeout;
    logic [15:0]       frame;

    assign fe      = kclk_prev_q & ~kclk_sync_q;
    assign timeout = (to_cnt_q == TimW'(TIMEOUT_CYCLES));
    // Index n holds the bit driven after fe number n; index 0 is the start bit.
    assign frame   = {5'h1f, 1'b1, parity_q, data_q, 1'b0};

    always_ff @(posedge keyboard_clk or negedge keyboard_rstn) begin
        if (!keyboard_rstn) begin
            kclk_meta_q  <= 1'b1;
            kclk_sync_q  <= 1'b1;
            kclk_prev_q  <= 1'b1;
            kdata_meta_q <= 1'b1;
            kdata_sync_q <= 1'b1;
        end else begin
            kclk_meta_q  <= kclk_in;
            kclk_sync_q  <= kclk_meta_q;
            kclk_prev_q  <= kclk_sync_q;
            kdata_meta_q <= kdata_in;
            kdata_sync_q <= kdata_meta_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        parity_d  = parity_q;
        bit_cnt_d = bit_cnt_q;
        inh_cnt_d = inh_cnt_q;
        to_cnt_d  = to_cnt_q;
        err_d     = err_q;

        unique case (state_q)
            StIdle: begin
                if (tx_valid && tx_ready_q) begin
                    data_d    = tx_data;
                    parity_d  = ~^tx_data;
                    inh_cnt_d = '0;
                    bit_cnt_d = '0;
                    err_d     = 1'b0;
                    state_d   = StInhibit;
                end
            end
            StInhibit: begin
                if (inh_cnt_q == InhW'(INHIBIT_CYCLES - 1)) begin
                    state_d = StRts;
                end else begin
                    inh_cnt_d = inh_cnt_q + 1'b1;
                end
            end
            StRts: begin
                to_cnt_d  = '0;
                bit_cnt_d = '0;
                state_d   = StSend;
            end
            StSend: begin
                if (fe) begin
                    to_cnt_d  = '0;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 4'd9) begin
                        state_d = StAck;
                    end
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            StAck: begin
                if (fe) begin
                    to_cnt_d = '0;
                    err_d    = kdata_sync_q;
                    state_d  = StWaitIdle;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            StWaitIdle: begin
                if (kclk_sync_q && kdata_sync_q) begin
                    state_d = StDone;
                end else if (fe) begin
                    to_cnt_d = '0;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are decoded from the next state so every pin comes directly off a flop.
    always_comb begin
        kclk_oe_d  = 1'b0;
        kdata_oe_d = 1'b0;
        tx_ready_d = 1'b0;
        tx_done_d  = 1'b0;
        tx_err_d   = 1'b0;
        case (state_d)
            StIdle: begin
                tx_ready_d = 1'b1;
            end
            StInhibit: begin
                kclk_oe_d = 1'b1;
            end
            StRts: begin
                kclk_oe_d  = 1'b1;
                kdata_oe_d = 1'b1;
            end
            StSend: begin
                kdata_oe_d = ~frame[bit_cnt_d];
            end
            StDone: begin
                tx_done_d = 1'b1;
                tx_err_d  = err_d;
            end
            default: begin
                kclk_oe_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge keyboard_clk or negedge keyboard_rstn) begin
        if (!keyboard_rstn) begin
            state_q    <= StIdle;
            data_q     <= '0;
            parity_q   <= 1'b0;
            bit_cnt_q  <= '0;
            inh_cnt_q  <= '0;
            to_cnt_q   <= '0;
            err_q      <= 1'b0;
            kclk_oe_q  <= 1'b0;
            kdata_oe_q <= 1'b0;
            tx_ready_q <= 1'b0;
            tx_done_q  <= 1'b0;
            tx_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            parity_q   <= parity_d;
            bit_cnt_q  <= bit_cnt_d;
            inh_cnt_q  <= inh_cnt_d;
            to_cnt_q   <= to_cnt_d;
            err_q      <= err_d;
            kclk_oe_q  <= kclk_oe_d;
            kdata_oe_q <= kdata_oe_d;
            tx_ready_q <= tx_ready_d;
            tx_done_q  <= tx_done_d;
            tx_err_q   <= tx_err_d;
        end
    end

    assign kclk_oe  = kclk_oe_q;
    assign kdata_oe = kdata_oe_q;
    assign tx_ready = tx_ready_q;
    assign tx_done  = tx_done_q;
    assign tx_err   = tx_err_q;

endmodule

// File: tb/tb_keyboard_tx.sv
// tb_keyboard_tx: PS/2 device model plus scoreboard for keyboard_tx; random and directed transfers,
// NACK, timeout, mid-transfer reset and back-to-back requests.
module tb_keyboard_tx;

    localparam int INHIBIT = 2000;
    localparam int TIMEOUT = 5000;
    localparam int MAck    = 0;
    localparam int MNack   = 1;
    localparam int MDead   = 2;
    localparam int MAbort  = 3;

    typedef struct {
        logic [7:0] d;
        int         mode;
    } cmd_t;

    logic       clk = 1'b0;
    logic       keyboard_rstn;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_err;
    logic       kclk_oe;
    logic       kdata_oe;
    logic       dev_clk;
    logic       dev_data;
    logic       kclk_line;
    logic       kdata_line;

    // Wired-AND open-drain bus between host and device.
    assign kclk_line  = ~kclk_oe & dev_clk;
    assign kdata_line = ~kdata_oe & dev_data;

    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;
    bit   abort_flag = 1'b0;
    cmd_t dev_q[$];
    bit   exp_q[$];

    always #5 clk = ~clk;

    keyboard_tx #(
        .INHIBIT_CYCLES(INHIBIT),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .keyboard_clk (clk),
        .keyboard_rstn(keyboard_rstn),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_done      (tx_done),
        .tx_err       (tx_err),
        .kclk_in      (kclk_line),
        .kdata_in     (kdata_line),
        .kclk_oe      (kclk_oe),
        .kdata_oe     (kdata_oe)
    );

    task automatic chk(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // PS/2 keyboard: watches the request, clocks 11 edges, samples each bit, then ACKs or NACKs.
    task automatic dev_xfer(input logic [7:0] d, input int mode);
        int          n;
        logic [10:0] got;
        logic [10:0] want;
        want[0] = 1'b0;
        for (int i = 0; i < 8; i++) want[i+1] = d[i];
        want[9]  = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
        want[10] = 1'b1;

        n = 0;
        while (!kclk_oe && n < 1000) begin @(negedge clk); n++; end
        chk(kclk_oe == 1'b1, "inhibit_start", kclk_oe, 1);
        n = 0;
        while (kclk_oe && !kdata_oe && n < 3 * INHIBIT) begin @(negedge clk); n++; end
        chk(n == INHIBIT, "inhibit_len", n, INHIBIT);
        n = 0;
        while (kclk_oe && kdata_oe && n < 10) begin @(negedge clk); n++; end
        chk(n == 1, "rts_len", n, 1);

        if (mode == MDead) begin
            n = 0;
            while (!tx_done && n < TIMEOUT + 100) begin @(negedge clk); n++; end
            chk(n >= TIMEOUT && n <= TIMEOUT + 2, "timeout_len", n, TIMEOUT);
            return;
        end

        repeat ($urandom_range(5, 15)) @(negedge clk);
        got[0] = kdata_line;
        for (int i = 1; i <= 10; i++) begin
            dev_clk = 1'b0;
            repeat (4) @(negedge clk);
            got[i] = kdata_line;
            repeat ($urandom_range(2, 10)) @(negedge clk);
            dev_clk = 1'b1;
            if (mode == MAbort && i == 4) begin
                abort_flag = 1'b1;
                return;
            end
            repeat ($urandom_range(5, 15)) @(negedge clk);
        end
        chk(got == want, "frame", got, want);

        dev_data = (mode == MNack) ? 1'b1 : 1'b0;
        repeat (3) @(negedge clk);
        dev_clk = 1'b0;
        repeat (8) @(negedge clk);
        dev_clk = 1'b1;
        repeat (2) @(negedge clk);
        dev_data = 1'b1;
    endtask

    initial begin
        cmd_t c;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        forever begin
            while (dev_q.size() == 0) @(negedge clk);
            c = dev_q.pop_front();
            dev_xfer(c.d, c.mode);
        end
    end

    // Monitor: every tx_done pops the oldest expected result.
    initial begin
        bit e;
        forever begin
            @(negedge clk);
            if (tx_done) begin
                done_cnt++;
                chk(!kclk_oe && !kdata_oe, "done_lines", {kclk_oe, kdata_oe}, 0);
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk(tx_err == e, "tx_err", tx_err, e);
                end
            end
        end
    end

    task automatic issue(input logic [7:0] d);
        int n;
        n = 0;
        while (!tx_ready && n < 1000) begin @(negedge clk); n++; end
        chk(tx_ready == 1'b1, "ready_wait", tx_ready, 1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 30000) begin @(negedge clk); n++; end
        chk(done_cnt >= target, "done_wait", done_cnt, target);
    endtask

    task automatic send(input logic [7:0] d, input int mode);
        int base;
        base = done_cnt;
        dev_q.push_back(cmd_t'{d, mode});
        if (mode != MAbort) exp_q.push_back(mode != MAck);
        issue(d);
        if (mode != MAbort) wait_done(base + 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   n;
        int   base;
        bit   saw_ready;
        logic [7:0] d1;
        logic [7:0] d2;

        keyboard_rstn = 1'b1;
        tx_valid      = 1'b0;
        tx_data       = 8'h00;
        #2 keyboard_rstn = 1'b0;
        repeat (3) @(negedge clk);
        chk({kclk_oe, kdata_oe, tx_ready, tx_done, tx_err} == 5'b0, "reset_state",
            {kclk_oe, kdata_oe, tx_ready, tx_done, tx_err}, 0);
        keyboard_rstn = 1'b1;
        @(negedge clk);
        chk(tx_ready == 1'b1, "ready_first_edge", tx_ready, 1);

        send(8'hED, MAck);
        send(8'h00, MAck);
        send(8'hFF, MAck);
        send(8'h5A, MNack);
        for (int i = 0; i < 5; i++) send(8'($urandom), int'($urandom_range(0, 1)));
        send(8'h3C, MDead);

        // Abort after the fourth falling edge; bit 3 of 8'h00 keeps data pulled low.
        abort_flag = 1'b0;
        send(8'h00, MAbort);
        n = 0;
        while (!abort_flag && n < 20000) begin @(negedge clk); n++; end
        chk(abort_flag == 1'b1, "abort_reach", abort_flag, 1);
        chk(!kclk_oe && kdata_oe, "abort_pre", {kclk_oe, kdata_oe}, 1);
        #3 keyboard_rstn = 1'b0;
        #1;
        chk(!kclk_oe && !kdata_oe, "async_release", {kclk_oe, kdata_oe}, 0);
        chk({tx_ready, tx_done, tx_err} == 3'b0, "reset_outputs", {tx_ready, tx_done, tx_err}, 0);
        repeat (3) @(negedge clk);
        keyboard_rstn = 1'b1;
        @(negedge clk);
        chk(tx_ready == 1'b1, "ready_after_reset", tx_ready, 1);
        send(8'hF4, MAck);

        // tx_valid held high across two back-to-back transfers.
        d1   = 8'($urandom);
        d2   = ~d1;
        base = done_cnt;
        dev_q.push_back(cmd_t'{d1, MAck});
        exp_q.push_back(1'b0);
        dev_q.push_back(cmd_t'{d2, MAck});
        exp_q.push_back(1'b0);
        n = 0;
        while (!tx_ready && n < 1000) begin @(negedge clk); n++; end
        tx_data  = d1;
        tx_valid = 1'b1;
        n = 0;
        while (!kclk_oe && n < 100) begin @(negedge clk); n++; end
        chk(kclk_oe == 1'b1, "held_accept", kclk_oe, 1);
        tx_data   = d2;
        saw_ready = 1'b0;
        n = 0;
        while (!tx_done && n < 30000) begin
            @(negedge clk);
            if (tx_ready) saw_ready = 1'b1;
            n++;
        end
        chk(saw_ready == 1'b0, "no_early_accept", saw_ready, 0);
        chk(tx_done == 1'b1, "held_done", tx_done, 1);
        chk(tx_ready == 1'b0, "ready_in_done", tx_ready, 0);
        @(negedge clk);
        chk(tx_ready && !kclk_oe, "idle_after_done", {tx_ready, kclk_oe}, 2);
        @(negedge clk);
        chk(kclk_oe && !tx_ready, "reaccept", {tx_ready, kclk_oe}, 1);
        tx_valid = 1'b0;
        wait_done(base + 2);
        chk(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);

        repeat (20) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
